oddr_serializer: RTL and testbench

Parametrised multi-lane output serializer with a built-in DDR output stage. It accepts RATIO-bit parallel words per lane over a valid/ready handshake. Each word is shifted out two bits per clock, one on the rising edge and one on the falling edge. Between words it drives a programmable idle level or a repeating training pattern. It sits between MAC-side TX logic and the pins, replacing hand-paired d1/d2 drive of single DDR flops.

---
 rtl/oddr_serializer_if.sv | 17 +
 rtl/oddr_serializer.sv | 105 ++++++++++
 tb/tb_oddr_serializer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/oddr_serializer_if.sv
// oddr_serializer_if
// Word handshake between the MAC-side TX logic and the DDR serializer.
//   s_data  : WIDTH*RATIO bits. Lane n occupies s_data[n*RATIO +: RATIO], and bit 0 of each lane is sent first.
//   s_valid : the source has a word available.
//   s_ready : the serializer accepts the word on a posedge where s_valid & s_ready.
// The master modport is the word source. The slave modport is the serializer.
interface oddr_serializer_if #(
   parameter int WIDTH = 1,
   parameter int RATIO = 4
);
   logic [WIDTH*RATIO-1:0] s_data;
   logic                   s_valid;
   logic                   s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/oddr_serializer.sv
// oddr_serializer
// Multi-lane output serializer with a built-in DDR output stage. It accepts one RATIO-bit word per
// lane and sends each word two bits per clock: an even bit in the high phase and an odd bit in the
// low phase. Between words it drives IDLE_LEVEL, or repeats a training pattern.
//   clk           : single clock. State updates on posedge. The low-phase output updates on negedge.
//   rst           : synchronous, active-high reset.
//   enable        : permits word acceptance. It takes effect at the next word boundary.
//   train_en      : requests training mode at the next word boundary.
//   train_pattern : RATIO-bit pattern sent on every lane while training.
//   s             : word handshake (slave side of oddr_serializer_if).
//   q             : DDR output lanes.
//   busy          : the serializer is sending a word or a training pattern.
//   underflow     : one-cycle pulse when a data word ends with no successor while enabled.
module oddr_serializer #(
   parameter int   WIDTH      = 1,
   parameter int   RATIO      = 4,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               train_en,
   input  logic [RATIO-1:0]   train_pattern,
   oddr_serializer_if.slave   s,
   output logic [WIDTH-1:0]   q,
   output logic               busy,
   output logic               underflow
);
   localparam int SLOTS = RATIO / 2;
   localparam int CW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_TRAIN = 2'd2;

   logic [1:0]             state;
   logic [CW-1:0]          cnt;
   logic [WIDTH*RATIO-1:0] shreg;
   logic [WIDTH-1:0]       q_hi;
   logic [WIDTH-1:0]       lo_cap;
   logic [WIDTH-1:0]       q_lo;
   logic                   boundary;
   logic                   accept;

   // A new word can only start at a boundary. s_ready is combinational, so the next word is
   // taken on the same edge that starts the last slot of the current word, and words stream
   // without a gap.
   assign boundary  = (state == ST_IDLE) || (cnt == LAST_SLOT);
   assign s.s_ready = enable & ~train_en & boundary & ~rst;
   assign accept    = s.s_valid & s.s_ready;
   assign busy      = (state != ST_IDLE) & ~rst;
   assign underflow = (state == ST_RUN) & (cnt == LAST_SLOT) & enable & ~train_en
                      & ~s.s_valid & ~rst;

   // Control and shift registers. At a boundary a training request wins over a data word.
   // Between boundaries each lane shifts down by two, so the current slot's pair always sits
   // in bits [1:0] of that lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else if (boundary) begin
         cnt <= '0;
         if (train_en) begin
            state <= ST_TRAIN;
            shreg <= {WIDTH{train_pattern}};
         end else if (accept) begin
            state <= ST_RUN;
            shreg <= s.s_data;
         end else begin
            state <= ST_IDLE;
         end
      end else begin
         cnt <= cnt + 1'b1;
         for (int n = 0; n < WIDTH; n++) begin
            shreg[n*RATIO +: RATIO] <= shreg[n*RATIO +: RATIO] >> 2;
         end
      end
   end

   // On posedge this captures both halves of the current slot. The high half goes out at once.
   // The low half waits in lo_cap for the falling edge. Reset loads the idle level here, so no
   // bits of an interrupted word ever reach the pins.
   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE) begin
         q_hi   <= {WIDTH{IDLE_LEVEL}};
         lo_cap <= {WIDTH{IDLE_LEVEL}};
      end else begin
         for (int n = 0; n < WIDTH; n++) begin
            q_hi[n]   <= shreg[n*RATIO];
            lo_cap[n] <= shreg[n*RATIO + 1];
         end
      end
   end

   // The low-phase register loads on the falling edge. Then each phase drives a value that was
   // stable before the phase began.
   always_ff @(negedge clk) begin
      q_lo <= lo_cap;
   end

   assign q = clk ? q_hi : q_lo;
endmodule

// File: tb/tb_oddr_serializer.sv
// tb_oddr_serializer
// Self-checking bench for oddr_serializer. It has two instances:
//   dut_a : WIDTH=2, RATIO=4, IDLE_LEVEL=0
//   dut_b : WIDTH=8, RATIO=2, IDLE_LEVEL=1
// The reference model keeps a queue of the (high, low) output pairs still owed to the pins.
// Each accepted word or training load appends RATIO/2 pairs, and each clock pops one.
module tb_oddr_serializer;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        train_en;
   logic [3:0]  pattern;
   logic        valid;
   logic [15:0] data;
   logic        sel;

   logic [1:0]  qa;
   logic [7:0]  qb;
   logic        busy_a, busy_b, uf_a, uf_b;

   logic [7:0]  obs_q;
   logic        obs_ready, obs_busy, obs_uf;

   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
   } pair_t;

   pair_t pend[$];
   bit    in_data;
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;

   always #5 clk = ~clk;

   oddr_serializer_if #(.WIDTH(2), .RATIO(4)) ifa ();
   oddr_serializer_if #(.WIDTH(8), .RATIO(2)) ifb ();

   assign ifa.s_data  = data[7:0];
   assign ifa.s_valid = valid;
   assign ifb.s_data  = data;
   assign ifb.s_valid = valid;

   oddr_serializer #(.WIDTH(2), .RATIO(4), .IDLE_LEVEL(1'b0)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .train_en(train_en),
      .train_pattern(pattern), .s(ifa), .q(qa), .busy(busy_a), .underflow(uf_a)
   );

   oddr_serializer #(.WIDTH(8), .RATIO(2), .IDLE_LEVEL(1'b1)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .train_en(train_en),
      .train_pattern(pattern[1:0]), .s(ifb), .q(qb), .busy(busy_b), .underflow(uf_b)
   );

   // Only the selected instance is observed. The other one sees the same inputs.
   always_comb begin
      obs_q     = sel ? qb : {6'b0, qa};
      obs_ready = sel ? ifb.s_ready : ifa.s_ready;
      obs_busy  = sel ? busy_b : busy_a;
      obs_uf    = sel ? uf_b : uf_a;
   end

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // One clock of the model. The inputs must be settled in the low phase before this task runs.
   task automatic tick();
      int         r, w;
      logic [7:0] idle8;
      bit         bnd, exp_ready;
      pair_t      e, p;
      r     = sel ? 2 : 4;
      w     = sel ? 8 : 2;
      idle8 = sel ? 8'hFF : 8'h00;
      #1;
      bnd       = (pend.size() <= 1);
      exp_ready = !rst && enable && !train_en && bnd;
      checkOutput("s_ready", obs_ready, exp_ready);
      checkOutput("busy", obs_busy, !rst && pend.size() > 0);
      checkOutput("underflow", obs_uf,
                  !rst && in_data && pend.size() == 1 && enable && !train_en && !valid);
      e.hi = idle8;
      e.lo = idle8;
      if (rst) begin
         pend.delete();
         in_data = 0;
      end else begin
         if (pend.size() > 0) e = pend.pop_front();
         if (bnd) begin
            if (train_en) begin
               for (int k = 0; k < r/2; k++) begin
                  p = '0;
                  for (int n = 0; n < w; n++) begin
                     p.hi[n] = pattern[2*k];
                     p.lo[n] = pattern[2*k+1];
                  end
                  pend.push_back(p);
               end
               in_data = 0;
            end else if (valid && exp_ready) begin
               for (int k = 0; k < r/2; k++) begin
                  p = '0;
                  for (int n = 0; n < w; n++) begin
                     p.hi[n] = data[n*r + 2*k];
                     p.lo[n] = data[n*r + 2*k + 1];
                  end
                  pend.push_back(p);
               end
               in_data = 1;
            end else begin
               in_data = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      checkOutput("q_high", obs_q, e.hi);
      @(negedge clk);
      #1;
      checkOutput("q_low", obs_q, e.lo);
      cyc++;
   endtask

   task automatic applyStimulus(input logic r, input logic en, input logic tr,
                                input logic [3:0] pat, input logic v, input logic [15:0] d);
      rst      = r;
      enable   = en;
      train_en = tr;
      pattern  = pat;
      valid    = v;
      data     = d;
      tick();
   endtask

   initial begin
      sel = 1'b0;
      rst = 1'b1; enable = 1'b0; train_en = 1'b0; pattern = '0; valid = 1'b0; data = '0;

      // Reset state
      applyStimulus(1, 0, 0, 4'h0, 0, 16'h0);
      applyStimulus(1, 0, 0, 4'h0, 0, 16'h0);

      // Single word, then idle with an underflow pulse on its last slot
      applyStimulus(0, 1, 0, 4'h0, 1, 16'h00B4);
      repeat (3) applyStimulus(0, 1, 0, 4'h0, 0, 16'h0);

      // Back-to-back words with s_valid held high
      applyStimulus(0, 1, 0, 4'h0, 1, 16'h005A);
      applyStimulus(0, 1, 0, 4'h0, 1, 16'h00C3);
      applyStimulus(0, 1, 0, 4'h0, 1, 16'h00C3);
      repeat (3) applyStimulus(0, 1, 0, 4'h0, 0, 16'h0);

      // Training requested mid-word, held, then released while a word waits
      applyStimulus(0, 1, 0, 4'h5, 1, 16'h0096);
      repeat (5) applyStimulus(0, 1, 1, 4'h5, 0, 16'h0);
      applyStimulus(0, 1, 1, 4'hA, 1, 16'h003C);
      repeat (3) applyStimulus(0, 1, 0, 4'hA, 1, 16'h003C);
      repeat (3) applyStimulus(0, 1, 0, 4'h0, 0, 16'h0);

      // Enable dropped at slot 0 while the source still offers a word
      applyStimulus(0, 1, 0, 4'h0, 1, 16'h00E1);
      repeat (4) applyStimulus(0, 0, 0, 4'h0, 1, 16'h0077);

      // Reset in the first slot of a word
      applyStimulus(0, 1, 0, 4'h0, 1, 16'h00FF);
      applyStimulus(1, 1, 0, 4'h0, 0, 16'h0);
      applyStimulus(1, 1, 0, 4'h0, 0, 16'h0);
      repeat (3) applyStimulus(0, 1, 0, 4'h0, 0, 16'h0);

      // Random traffic on the 2-lane instance
      for (int i = 0; i < 150; i++) begin
         applyStimulus(($urandom % 60) == 0, ($urandom % 8) != 0, ($urandom % 10) == 0,
                       4'($urandom), ($urandom % 3) != 0, 16'($urandom));
      end

      // 8-lane instance with RATIO=2 and idle-high outputs
      sel = 1'b1;
      applyStimulus(1, 0, 0, 4'h0, 0, 16'h0);
      applyStimulus(1, 0, 0, 4'h0, 0, 16'h0);
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom % 100) == 0, ($urandom % 16) != 0, ($urandom % 25) == 0,
                       4'($urandom), ($urandom % 3) != 0, 16'($urandom));
      end
      repeat (3) applyStimulus(0, 1, 0, 4'h0, 0, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
